// File: rtl/ode_ram_arbiter.sv
// Grants one of three requesters the RAM bank and steers its beats onto the bank bus. Reads return one cycle later.
// Option ODE_ARB_BURST_LOCK_EN holds a grant for a whole burst; without it every accepted beat re-arbitrates.
module ode_ram_arbiter #(
    parameter int AW        = 16,
    parameter int DW        = 64,
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        req,
    input  logic [2:0]        wr,
    input  logic [2:0]        last,
    input  logic [3*AW-1:0]   addr,
    input  logic [3*DW-1:0]   wdata,
    output logic [2:0]        gnt,
    output logic [2:0]        rvalid,
    output logic [DW-1:0]     rdata,
    output logic [1:0]        ram_wr_rd,
    output logic [AW-1:0]     ram_addr,
    output logic [DW-1:0]     ram_wdata,
    input  logic [DW-1:0]     ram_rdata,
    output logic              busy,
    output logic [1:0]        owner
);

    // The state value doubles as the owner index, so IDLE is encoded as 3.
    typedef enum logic [1:0] {
        S_P0   = 2'd0,
        S_P1   = 2'd1,
        S_P2   = 2'd2,
        S_IDLE = 2'd3
    } state_t;

    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    state_t          state;
    state_t          state_nxt;
    state_t          pick;
    logic [1:0]      rr;
    logic [1:0]      rr_alt;
    logic            own_req;
    logic            own_wr;
    logic            own_last;
    logic [AW-1:0]   own_addr;
    logic [DW-1:0]   own_wdata;
    logic            accept;
    logic            grant_end;
    logic            arb_now;
    logic [AW-1:0]   addr_hold;
    logic [DW-1:0]   wdata_hold;
    logic [2:0]      rvalid_q;

    always_comb begin
        own_req   = 1'b0;
        own_wr    = 1'b0;
        own_last  = 1'b0;
        own_addr  = '0;
        own_wdata = '0;
        if (state != S_IDLE) begin
            own_req   = req[state];
            own_wr    = wr[state];
            own_last  = last[state];
            own_addr  = addr[int'(state)*AW +: AW];
            own_wdata = wdata[int'(state)*DW +: DW];
        end
    end

    assign accept = own_req;

`ifdef ODE_ARB_BURST_LOCK_EN
    logic [7:0] beat_cnt;

    assign grant_end = (state != S_IDLE) &&
                       (!own_req || own_last || (beat_cnt == BURST_LAST));

    always_ff @(posedge clk) begin
        if (rst)
            beat_cnt <= '0;
        else if (grant_end)
            beat_cnt <= '0;
        else if (accept)
            beat_cnt <= beat_cnt + 8'd1;
    end
`else
    logic unused_cfg;

    // A held grant either takes a beat or is withdrawn, so it always ends here.
    assign grant_end  = (state != S_IDLE);
    assign unused_cfg = ^{own_last, BURST_LAST};
`endif

    assign arb_now = (state == S_IDLE) || grant_end;
    assign rr_alt  = 2'd3 - rr;

    // Port 0 first, then the round-robin preferred port, then the other one.
    always_comb begin
        pick = S_IDLE;
        if (req[0])
            pick = S_P0;
        else if (req[rr])
            pick = state_t'(rr);
        else if (req[rr_alt])
            pick = state_t'(rr_alt);
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (arb_now)
            state_nxt = pick;
    end

    always_comb begin
        gnt       = 3'b000;
        ram_wr_rd = 2'b00;
        ram_addr  = addr_hold;
        ram_wdata = wdata_hold;
        busy      = (state != S_IDLE);
        owner     = state;
        if (state != S_IDLE)
            gnt[state] = 1'b1;
        if (accept) begin
            ram_wr_rd = {own_wr, ~own_wr};
            ram_addr  = own_addr;
            ram_wdata = own_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            rr <= 2'd1;
        else if (arb_now && (pick == S_P1))
            rr <= 2'd2;
        else if (arb_now && (pick == S_P2))
            rr <= 2'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_hold  <= '0;
            wdata_hold <= '0;
            rvalid_q   <= 3'b000;
        end else begin
            if (accept) begin
                addr_hold  <= own_addr;
                wdata_hold <= own_wdata;
            end
            rvalid_q <= (accept && !own_wr) ? gnt : 3'b000;
        end
    end

    assign rvalid = rvalid_q;
    assign rdata  = ram_rdata;

endmodule
